// File: rtl/uart_cmd_parser.sv
// Frames uart rx bytes (SYNC, OPCODE, LEN, payload, CHK) into host commands.
// Payload streams to a write port; a checksum-validated command is offered via valid/ready.
module uart_cmd_parser #(
    parameter int          DATA_W         = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          MAX_LEN        = 16,
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    localparam int         ADDR_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              pl_we,
    output logic [ADDR_W-1:0] pl_addr,
    output logic [DATA_W-1:0] pl_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DATA_W-1:0] cmd_opcode,
    output logic [ADDR_W:0]   cmd_len,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Counter value at which this edge would bring it to TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_OPCODE, S_LEN, S_PAYLOAD, S_CHECK, S_HOLD
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    to_cnt;
    logic [DATA_W-1:0]   chk;
    logic [DATA_W-1:0]   opcode_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            to_cnt      <= '0;
            chk         <= '0;
            opcode_q    <= '0;
            len_q       <= '0;
            idx         <= '0;
            pl_we       <= 1'b0;
            pl_addr     <= '0;
            pl_data     <= '0;
            cmd_valid   <= 1'b0;
            cmd_opcode  <= '0;
            cmd_len     <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pl_we       <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state <= S_OPCODE;
                        busy  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    to_cnt <= '0;
                    // Bytes arriving while a command is pending are dropped, sync included.
                    if (rx_valid)
                        err_overrun <= 1'b1;
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        to_cnt <= '0;
                        case (state)
                            S_OPCODE: begin
                                opcode_q <= rx_data;
                                chk      <= rx_data;
                                state    <= S_LEN;
                            end
                            S_LEN: begin
                                len_q <= rx_data[ADDR_W:0];
                                chk   <= chk ^ rx_data;
                                idx   <= '0;
                                if (rx_data > DATA_W'(MAX_LEN)) begin
                                    err_len <= 1'b1;
                                    state   <= S_IDLE;
                                    busy    <= 1'b0;
                                end else if (rx_data == '0) begin
                                    state <= S_CHECK;
                                end else begin
                                    state <= S_PAYLOAD;
                                end
                            end
                            S_PAYLOAD: begin
                                pl_we   <= 1'b1;
                                pl_addr <= idx;
                                pl_data <= rx_data;
                                chk     <= chk ^ rx_data;
                                if ({1'b0, idx} == len_q - 1'b1)
                                    state <= S_CHECK;
                                else
                                    idx <= idx + 1'b1;
                            end
                            S_CHECK: begin
                                if (rx_data == chk) begin
                                    cmd_valid  <= 1'b1;
                                    cmd_opcode <= opcode_q;
                                    cmd_len    <= len_q;
                                    state      <= S_HOLD;
                                end else begin
                                    err_chk <= 1'b1;
                                    state   <= S_IDLE;
                                    busy    <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        to_cnt      <= '0;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: framing, errors, timeout, overrun and reset.
module tb_uart_cmd_parser;

    localparam int DATA_W = 8;
    localparam int MAX_LEN = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              cmd_ready = 1'b0;
    logic              pl_we;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;
    logic              cmd_valid;
    logic [DATA_W-1:0] cmd_opcode;
    logic [ADDR_W:0]   cmd_len;
    logic              err_chk, err_len, err_timeout, err_overrun, busy;

    int n_chk = 0;
    int n_err = 0;

    // Pulse observers, sampled on the falling edge.
    int pl_cnt = 0, cmd_rise = 0;
    int n_echk = 0, n_elen = 0, n_eto = 0, n_eovr = 0;
    logic [DATA_W-1:0] pl_mem [MAX_LEN];
    logic cv_q = 1'b0;

    uart_cmd_parser #(
        .DATA_W(DATA_W), .SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_len(cmd_len),
        .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout), .err_overrun(err_overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pl_we) begin
            pl_mem[pl_addr] = pl_data;
            pl_cnt++;
        end
        if (cmd_valid && !cv_q) cmd_rise++;
        cv_q = cmd_valid;
        n_echk += int'(err_chk);
        n_elen += int'(err_len);
        n_eto  += int'(err_timeout);
        n_eovr += int'(err_overrun);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one byte for a single cycle; returns just after its outputs settle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic release_cmd(input string tag);
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        #1;
        check({tag, "_vdrop"}, {31'd0, cmd_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        cmd_ready = 1'b0;
    endtask

    function automatic int err_sum();
        return n_echk + n_elen + n_eto + n_eovr;
    endfunction

    initial begin
        int pl0, rise0, e0, n;
        logic [7:0] f1 [6];
        f1 = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outs", {23'd0, pl_we, cmd_valid, err_chk, err_len, err_timeout, err_overrun,
                           pl_addr == '0, pl_data == '0, cmd_len == '0}, 32'h7);
        check("rst_opc", {24'd0, cmd_opcode}, 32'd0);
        rst = 1'b0;

        // Good frame, two payload bytes
        pl0 = pl_cnt; e0 = err_sum();
        foreach (f1[i]) send_byte(f1[i]);
        check("f1_plcnt", pl_cnt - pl0, 2);
        check("f1_pl0", {24'd0, pl_mem[0]}, 32'h11);
        check("f1_pl1", {24'd0, pl_mem[1]}, 32'h22);
        check("f1_valid", {31'd0, cmd_valid}, 32'd1);
        check("f1_opc", {24'd0, cmd_opcode}, 32'h01);
        check("f1_len", {27'd0, cmd_len}, 32'd2);
        check("f1_noerr", err_sum() - e0, 0);

        // Overrun in HOLD, sync byte included
        send_byte(8'h55);
        check("ovr_pulse", {31'd0, err_overrun}, 32'd1);
        send_byte(8'hA5);
        check("ovr_cnt", n_eovr, 2);
        check("ovr_valid", {31'd0, cmd_valid}, 32'd1);
        check("ovr_opc", {24'd0, cmd_opcode}, 32'h01);
        check("ovr_len", {27'd0, cmd_len}, 32'd2);
        @(negedge clk);
        #1;
        check("ovr_1cyc", {31'd0, err_overrun}, 32'd0);
        release_cmd("f1");

        // Bad checksum, then a good frame
        rise0 = cmd_rise; e0 = n_echk;
        f1[5] = 8'h31;
        foreach (f1[i]) send_byte(f1[i]);
        check("bad_echk", {31'd0, err_chk}, 32'd1);
        @(negedge clk);
        #1;
        check("bad_echk_1", n_echk - e0, 1);
        check("bad_norise", cmd_rise - rise0, 0);
        check("bad_idle", {31'd0, busy}, 32'd0);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        send_byte(8'h7E); send_byte(8'h7C);
        check("f2_pl0", {24'd0, pl_mem[0]}, 32'h7E);
        check("f2_valid", {31'd0, cmd_valid}, 32'd1);
        check("f2_opc_len", {19'd0, cmd_opcode, cmd_len}, {19'd0, 8'h03, 5'd1});
        release_cmd("f2");

        // Garbage then zero-length frame
        pl0 = pl_cnt; e0 = err_sum();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("garb_idle", {31'd0, busy}, 32'd0);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
        check("z_valid", {31'd0, cmd_valid}, 32'd1);
        check("z_opc_len", {19'd0, cmd_opcode, cmd_len}, {19'd0, 8'h07, 5'd0});
        check("z_nopl", pl_cnt - pl0, 0);
        check("z_noerr", err_sum() - e0, 0);
        release_cmd("z");

        // LEN beyond MAX_LEN
        pl0 = pl_cnt; e0 = n_elen;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
        check("len_pulse", {31'd0, err_len}, 32'd1);
        check("len_idle", {31'd0, busy}, 32'd0);
        check("len_nopl", pl_cnt - pl0, 0);

        // Timeout 99 cycles after the last byte
        e0 = n_eto;
        send_byte(8'hA5); send_byte(8'h01);
        n = 0;
        while (!err_timeout && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("to_delay", n, 99);
        check("to_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #1;
        check("to_once", n_eto - e0, 1);

        // Reset mid-payload
        e0 = err_sum();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03); send_byte(8'h11);
        check("mid_plwe", {31'd0, pl_we}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {23'd0, pl_we, cmd_valid, err_chk, err_len, err_timeout, err_overrun,
                               busy, pl_addr == '0, cmd_len == '0}, 32'h3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_noerr", err_sum() - e0, 0);
        foreach (f1[i]) send_byte(i == 5 ? 8'h30 : f1[i]);
        check("post_rst_valid", {31'd0, cmd_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
